// File: rtl/hazard_track_pkg.sv
// -----------------------------------------------------------------------------
// hazard_track_pkg
// Shared MCU defines for the hazard tracking slice: register-file address
// width, the architectural PC register number, the per-stage pipeline record
// layouts and the PC-aware address compare used by every match output.
// -----------------------------------------------------------------------------
package hazard_track_pkg;

  localparam int REG_W = 4;
  localparam logic [REG_W-1:0] REG_PC = 4'hF;

  typedef logic [REG_W-1:0] reg_addr_t;

  // Decoded controls carried through E.
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic pc_src;
    logic branch;
  } ctrl_e_t;

  typedef struct packed {
    reg_addr_t ra1;
    reg_addr_t ra2;
    reg_addr_t wa3;
    ctrl_e_t   ctrl;
  } stage_e_t;

  typedef struct packed {
    reg_addr_t wa3;
    logic      reg_write;
    logic      mem_to_reg;
    logic      pc_src;
  } stage_m_t;

  typedef struct packed {
    reg_addr_t wa3;
    logic      reg_write;
    logic      pc_src;
  } stage_w_t;

  // A source reading the PC never takes a forwarded value: the PC is read
  // from the fetch path, not from the register file, so its compare is masked.
  function automatic logic addr_match(input reg_addr_t src, input reg_addr_t dst);
    return (src == dst) && (src != REG_PC);
  endfunction

endpackage

// File: rtl/pipe_flop.sv
// -----------------------------------------------------------------------------
// pipe_flop
// Generic pipeline register: asynchronous active-high reset, synchronous
// clear and load enable. Clear wins over enable so a flush always lands even
// when the stage is otherwise holding.
//
// Ports
//   clk    in  1  rising-edge clock
//   reset  in  1  asynchronous active-high reset, q -> 0
//   en     in  1  load enable
//   clr    in  1  synchronous clear, q -> 0 on the next edge
//   d      in  W  next value
//   q      out W  registered value
// -----------------------------------------------------------------------------
module pipe_flop #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_track.sv
// -----------------------------------------------------------------------------
// hazard_track
// Tracks register addresses and write/branch controls down the D->E->M->W
// pipeline and produces the address compares and qualified controls the
// hazard unit needs for forwarding, load-use stalls and PC-write flushing.
// All state lives in pipe_flop instances: ValidD plus the E, M and W records.
//
// Ports
//   clk, reset                          clock, async active-high reset
//   RA1D, RA2D, WA3D           in  4    D-stage source/destination addresses
//   RegWriteD, MemtoRegD,
//   PCSrcD, BranchD            in  1    D-stage decoded controls
//   CondExE                    in  1    E-stage condition passed
//   StallD, FlushD, FlushE     in  1    pipeline controls from hazard unit
//   Match_1E_M, Match_1E_W,
//   Match_2E_M, Match_2E_W     out 1    E sources vs M/W destinations
//   Match_12D_E                out 1    D sources vs E destination
//   RegWriteM, RegWriteW,
//   MemtoRegE, PCSrcW,
//   BranchTakenE, PCWrPendingF out 1    qualified controls
// -----------------------------------------------------------------------------
module hazard_track
  import hazard_track_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] RA1D,
  input  logic [REG_W-1:0] RA2D,
  input  logic [REG_W-1:0] WA3D,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             PCSrcD,
  input  logic             BranchD,
  input  logic             CondExE,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             FlushE,
  output logic             Match_1E_M,
  output logic             Match_1E_W,
  output logic             Match_2E_M,
  output logic             Match_2E_W,
  output logic             Match_12D_E,
  output logic             RegWriteM,
  output logic             RegWriteW,
  output logic             MemtoRegE,
  output logic             PCSrcW,
  output logic             BranchTakenE,
  output logic             PCWrPendingF
);

  logic     valid_d;
  stage_e_t e_d, e_q;
  stage_m_t m_d, m_q;
  stage_w_t w_d, w_q;

  // MemtoRegM feeds the write-back mux outside this block; nothing here
  // reads it, so it is parked on a sink net.
  logic     unused_mem_to_reg_m;

  // ValidD: FlushD clears (clr beats en), StallD holds, otherwise set.
  pipe_flop #(.W(1)) u_valid_d (
    .clk   (clk),
    .reset (reset),
    .en    (~StallD),
    .clr   (FlushD),
    .d     (1'b1),
    .q     (valid_d)
  );

  // D->E: controls are killed for an invalid D slot; addresses pass as-is.
  always_comb begin
    e_d                = '0;
    e_d.ra1            = RA1D;
    e_d.ra2            = RA2D;
    e_d.wa3            = WA3D;
    e_d.ctrl.reg_write = RegWriteD & valid_d;
    e_d.ctrl.mem_to_reg= MemtoRegD & valid_d;
    e_d.ctrl.pc_src    = PCSrcD & valid_d;
    e_d.ctrl.branch    = BranchD & valid_d;
  end

  pipe_flop #(.W($bits(stage_e_t))) u_stage_e (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .clr   (FlushE),
    .d     (e_d),
    .q     (e_q)
  );

  // E->M: a failed condition turns the instruction into a no-op for
  // register and PC writes.
  always_comb begin
    m_d            = '0;
    m_d.wa3        = e_q.wa3;
    m_d.reg_write  = e_q.ctrl.reg_write & CondExE;
    m_d.mem_to_reg = e_q.ctrl.mem_to_reg;
    m_d.pc_src     = e_q.ctrl.pc_src & CondExE;
  end

  pipe_flop #(.W($bits(stage_m_t))) u_stage_m (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .clr   (1'b0),
    .d     (m_d),
    .q     (m_q)
  );

  always_comb begin
    w_d           = '0;
    w_d.wa3       = m_q.wa3;
    w_d.reg_write = m_q.reg_write;
    w_d.pc_src    = m_q.pc_src;
  end

  pipe_flop #(.W($bits(stage_w_t))) u_stage_w (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .clr   (1'b0),
    .d     (w_d),
    .q     (w_q)
  );

  assign unused_mem_to_reg_m = m_q.mem_to_reg;

  // Compares are deliberately not qualified by RegWrite; the hazard unit
  // combines them with RegWriteM/RegWriteW itself.
  assign Match_1E_M  = addr_match(e_q.ra1, m_q.wa3);
  assign Match_1E_W  = addr_match(e_q.ra1, w_q.wa3);
  assign Match_2E_M  = addr_match(e_q.ra2, m_q.wa3);
  assign Match_2E_W  = addr_match(e_q.ra2, w_q.wa3);
  assign Match_12D_E = addr_match(RA1D, e_q.wa3) | addr_match(RA2D, e_q.wa3);

  assign RegWriteM    = m_q.reg_write;
  assign RegWriteW    = w_q.reg_write;
  assign MemtoRegE    = e_q.ctrl.mem_to_reg;
  assign PCSrcW       = w_q.pc_src;
  assign BranchTakenE = e_q.ctrl.branch & CondExE;

  // A PC write is pending from the moment a valid PC-writing instruction is
  // decoded until it leaves M; PCSrcM already carries the condition result.
  assign PCWrPendingF = (PCSrcD & valid_d) | e_q.ctrl.pc_src | m_q.pc_src;

endmodule
